// File: rtl/inst_decode_if.sv
// Boundary of the RV32I decode stage: fetch inputs, register-file read port,
// pipeline control and the registered decode results handed to execute.
interface inst_decode_if;
  logic        stall;
  logic        flush;
  logic        load_use;
  logic [31:0] i_pc;
  logic [31:0] i_inst;
  logic        i_valid;
  logic [4:0]  reg_raddr1;
  logic [4:0]  reg_raddr2;
  logic [31:0] reg_rdata1;
  logic [31:0] reg_rdata2;
  logic [31:0] d_pc;
  logic [31:0] d_inst;
  logic        d_valid;
  logic [6:0]  d_opcode;
  logic [2:0]  d_funct3;
  logic [6:0]  d_funct7;
  logic [4:0]  d_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [31:0] d_rs1_v;
  logic [31:0] d_rs2_v;
  logic [31:0] d_imm;
  logic        d_illegal;

  modport master (
    output stall, flush, i_pc, i_inst, i_valid, reg_rdata1, reg_rdata2,
    input  load_use, reg_raddr1, reg_raddr2,
    input  d_pc, d_inst, d_valid, d_opcode, d_funct3, d_funct7, d_rd,
    input  d_rs1, d_rs2, d_rs1_v, d_rs2_v, d_imm, d_illegal
  );

  modport slave (
    input  stall, flush, i_pc, i_inst, i_valid, reg_rdata1, reg_rdata2,
    output load_use, reg_raddr1, reg_raddr2,
    output d_pc, d_inst, d_valid, d_opcode, d_funct3, d_funct7, d_rd,
    output d_rs1, d_rs2, d_rs1_v, d_rs2_v, d_imm, d_illegal
  );
endinterface

// File: rtl/inst_decode.sv
// RV32I decode stage: classifies the fetched instruction, builds its immediate,
// captures operands one cycle later and raises a load-use bubble when needed.
module inst_decode #(
  parameter bit C_ILLEGAL_CHECK = 1'b1
) (
  input logic          clk,
  input logic          rst,
  inst_decode_if.slave dec
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

  // opcode/funct fields are re-sliced from the registered raw instruction.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  logic [31:0] inst;
  fmt_e        fmt;
  dec_t        nxt;
  dec_t        q;
  logic        rs1_used;
  logic        rs2_used;

  assign inst           = dec.i_inst;
  assign dec.reg_raddr1 = inst[19:15];
  assign dec.reg_raddr2 = inst[24:20];

  always_comb begin
    case (inst[6:0])
      7'b0110011:                                             fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: fmt = FMT_I;
      7'b0100011:                                             fmt = FMT_S;
      7'b1100011:                                             fmt = FMT_B;
      7'b0110111, 7'b0010111:                                 fmt = FMT_U;
      7'b1101111:                                             fmt = FMT_J;
      default:                                                fmt = FMT_X;
    endcase
  end

  // NOTE: every field gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    nxt       = '0;
    nxt.pc    = dec.i_pc;
    nxt.inst  = inst;
    nxt.valid = dec.i_valid;
    nxt.rd    = inst[11:7];
    nxt.rs1   = inst[19:15];
    case (fmt)
      FMT_R: nxt.rs2 = inst[24:20];
      FMT_I: nxt.imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S: begin
        nxt.rd  = '0;
        nxt.rs2 = inst[24:20];
        nxt.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      FMT_B: begin
        nxt.rd  = '0;
        nxt.rs2 = inst[24:20];
        nxt.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      FMT_U: begin
        nxt.rs1 = '0;
        nxt.imm = {inst[31:12], 12'b0};
      end
      FMT_J: begin
        nxt.rs1 = '0;
        nxt.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: ;
    endcase
    // x0 always reads as zero, whatever the register file returns.
    nxt.rs1_v   = (nxt.rs1 == '0) ? '0 : dec.reg_rdata1;
    nxt.rs2_v   = (nxt.rs2 == '0) ? '0 : dec.reg_rdata2;
    nxt.illegal = C_ILLEGAL_CHECK && dec.i_valid && (fmt == FMT_X || inst[1:0] != 2'b11);
  end

  assign rs1_used = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign rs2_used = fmt inside {FMT_R, FMT_S, FMT_B};

  assign dec.load_use = q.valid && (q.inst[6:0] == OP_LOAD) && (q.rd != '0) && dec.i_valid &&
                        ((rs1_used && inst[19:15] == q.rd) || (rs2_used && inst[24:20] == q.rd)) &&
                        !dec.stall && !dec.flush;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (dec.stall) begin
      q <= q;
    end else if (dec.flush || dec.load_use) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

  assign dec.d_pc      = q.pc;
  assign dec.d_inst    = q.inst;
  assign dec.d_valid   = q.valid;
  assign dec.d_opcode  = q.inst[6:0];
  assign dec.d_funct3  = q.inst[14:12];
  assign dec.d_funct7  = q.inst[31:25];
  assign dec.d_rd      = q.rd;
  assign dec.d_rs1     = q.rs1;
  assign dec.d_rs2     = q.rs2;
  assign dec.d_rs1_v   = q.rs1_v;
  assign dec.d_rs2_v   = q.rs2_v;
  assign dec.d_imm     = q.imm;
  assign dec.d_illegal = q.illegal;

endmodule

// File: tb/tb_inst_decode.sv
// Bench for inst_decode: directed instructions followed by randomly encoded ones,
// all checked against an instruction-level model of the decode register.
module tb_inst_decode;

  typedef enum {K_R, K_I, K_S, K_B, K_U, K_J, K_BAD} kind_e;

  typedef struct {
    logic [31:0] inst;
    kind_e       kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } txn_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          valid;
    bit          known;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] imm;
    bit          illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rf [32];
  exp_t        m;
  int          n_checks = 0;
  int          n_pass   = 0;

  inst_decode_if dif ();

  inst_decode #(.C_ILLEGAL_CHECK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .dec (dif)
  );

  always #5 clk = ~clk;

  assign dif.reg_rdata1 = rf[dif.reg_raddr1];
  assign dif.reg_rdata2 = rf[dif.reg_raddr2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  function automatic txn_t mk(input logic [31:0] inst, input kind_e kind, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    txn_t t;
    t.inst = inst; t.kind = kind; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    return t;
  endfunction

  function automatic bit listed(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111,
                      7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
  endfunction

  // Picks a format and an immediate value first, then encodes the instruction from them.
  function automatic txn_t rand_txn();
    txn_t        t;
    logic [31:0] r, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  i_ops [5];
    int          k;
    i_ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111};
    r   = $urandom();
    rd  = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    t   = mk(32'h0, K_R, rd, rs1, 5'd0, 32'h0);
    k   = int'($urandom_range(0, 8));
    case (k)
      0: begin
        t.rs2  = rs2;
        t.inst = {r[31:25], rs2, rs1, r[14:12], rd, 7'b0110011};
      end
      1, 2, 7: begin
        t.kind = K_I;
        imm    = 32'($urandom_range(0, 4095)) - 32'd2048;
        t.imm  = imm;
        t.inst = {imm[11:0], rs1, r[14:12], rd, (k == 7) ? 7'b0000011 : i_ops[$urandom_range(0, 4)]};
      end
      3: begin
        t.kind = K_S; t.rd = 5'd0; t.rs2 = rs2;
        imm    = 32'($urandom_range(0, 4095)) - 32'd2048;
        t.imm  = imm;
        t.inst = {imm[11:5], rs2, rs1, r[14:12], imm[4:0], 7'b0100011};
      end
      4: begin
        t.kind = K_B; t.rd = 5'd0; t.rs2 = rs2;
        imm    = 32'd2 * 32'($urandom_range(0, 4095)) - 32'd4096;
        t.imm  = imm;
        t.inst = {imm[12], imm[10:5], rs2, rs1, r[14:12], imm[4:1], imm[11], 7'b1100011};
      end
      5: begin
        t.kind = K_U; t.rs1 = 5'd0;
        imm    = {r[31:12], 12'h000};
        t.imm  = imm;
        t.inst = {imm[31:12], rd, r[0] ? 7'b0110111 : 7'b0010111};
      end
      6: begin
        t.kind = K_J; t.rs1 = 5'd0;
        imm    = 32'd2 * 32'($urandom_range(0, 1048575)) - 32'd1048576;
        t.imm  = imm;
        t.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      end
      default: begin
        do r = $urandom(); while (listed(r[6:0]));
        t = mk(r, K_BAD, r[11:7], r[19:15], 5'd0, 32'h0);
      end
    endcase
    return t;
  endfunction

  function automatic bit exp_lu(input txn_t t, input bit valid, input bit stall, input bit flush);
    bit hit1, hit2;
    hit1 = (t.kind inside {K_R, K_I, K_S, K_B}) && (t.inst[19:15] == m.rd);
    hit2 = (t.kind inside {K_R, K_S, K_B}) && (t.inst[24:20] == m.rd);
    return m.valid && (m.inst[6:0] == 7'b0000011) && (m.rd != 5'd0) && valid &&
           (hit1 || hit2) && !stall && !flush;
  endfunction

  task automatic model_clear();
    m = '{default: '0};
    m.known = 1'b1;
  endtask

  task automatic check_outputs();
    check("d_valid", 32'(dif.d_valid), 32'(m.valid));
    if (m.known) begin
      check("d_pc",      dif.d_pc,               m.pc);
      check("d_inst",    dif.d_inst,             m.inst);
      check("d_opcode",  32'(dif.d_opcode),      32'(m.inst[6:0]));
      check("d_funct3",  32'(dif.d_funct3),      32'(m.inst[14:12]));
      check("d_funct7",  32'(dif.d_funct7),      32'(m.inst[31:25]));
      check("d_rd",      32'(dif.d_rd),          32'(m.rd));
      check("d_rs1",     32'(dif.d_rs1),         32'(m.rs1));
      check("d_rs2",     32'(dif.d_rs2),         32'(m.rs2));
      check("d_rs1_v",   dif.d_rs1_v,            m.rs1_v);
      check("d_rs2_v",   dif.d_rs2_v,            m.rs2_v);
      check("d_imm",     dif.d_imm,              m.imm);
      check("d_illegal", 32'(dif.d_illegal),     32'(m.illegal));
    end
  endtask

  // One pipeline cycle: drive on the falling edge, check the hazard, capture, check outputs.
  task automatic step(input txn_t t, input bit valid, input bit stall, input bit flush,
                      input logic [31:0] pc, output bit lu);
    @(negedge clk);
    dif.i_inst  = t.inst;
    dif.i_pc    = pc;
    dif.i_valid = valid;
    dif.stall   = stall;
    dif.flush   = flush;
    #1;
    lu = exp_lu(t, valid, stall, flush);
    check("load_use",   32'(dif.load_use),   32'(lu));
    check("reg_raddr1", 32'(dif.reg_raddr1), 32'(t.inst[19:15]));
    check("reg_raddr2", 32'(dif.reg_raddr2), 32'(t.inst[24:20]));
    @(posedge clk);
    if (!stall) begin
      if (flush || lu) begin
        model_clear();
      end else begin
        m.pc      = pc;
        m.inst    = t.inst;
        m.valid   = valid;
        m.known   = valid;
        m.rd      = t.rd;
        m.rs1     = t.rs1;
        m.rs2     = t.rs2;
        m.rs1_v   = (t.rs1 == 5'd0) ? 32'h0 : rf[t.rs1];
        m.rs2_v   = (t.rs2 == 5'd0) ? 32'h0 : rf[t.rs2];
        m.imm     = t.imm;
        m.illegal = valid && (t.kind == K_BAD);
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    txn_t        t_addi, t_beq, t_lui, t_lw, t_add, t_bad, t;
    bit          lu, v, st, fl;
    logic [31:0] pc;

    for (int i = 0; i < 32; i++) rf[i] = $urandom();
    rf[0] = 32'hDEAD_BEEF;
    rf[2] = 32'd7;

    rst = 1'b1;
    dif.stall = 1'b0; dif.flush = 1'b0; dif.i_valid = 1'b0;
    dif.i_pc  = 32'h0; dif.i_inst = 32'h0;
    #2;
    model_clear();
    check_outputs();
    check("load_use_rst", 32'(dif.load_use), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    t_addi = mk(32'h00510093, K_I,   5'd1, 5'd2, 5'd0, 32'd5);
    t_beq  = mk(32'hFE000EE3, K_B,   5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    t_lui  = mk(32'h123452B7, K_U,   5'd5, 5'd0, 5'd0, 32'h1234_5000);
    t_lw   = mk(32'h0000A183, K_I,   5'd3, 5'd1, 5'd0, 32'h0);
    t_add  = mk(32'h00218233, K_R,   5'd4, 5'd3, 5'd2, 32'h0);
    t_bad  = mk(32'h0000007F, K_BAD, 5'd0, 5'd0, 5'd0, 32'h0);

    step(t_addi, 1'b1, 1'b0, 1'b0, 32'h100, lu);
    step(t_beq,  1'b1, 1'b0, 1'b0, 32'h104, lu);
    step(t_lui,  1'b1, 1'b0, 1'b0, 32'h108, lu);
    step(t_lw,   1'b1, 1'b0, 1'b0, 32'h10C, lu);
    step(t_add,  1'b1, 1'b0, 1'b0, 32'h110, lu);
    check("lw_add_hazard", 32'(dif.d_valid), 32'(!lu));
    step(t_add,  1'b1, 1'b0, 1'b0, 32'h110, lu);
    step(t_lui,  1'b1, 1'b1, 1'b1, 32'h114, lu);
    step(t_lui,  1'b1, 1'b0, 1'b1, 32'h114, lu);
    step(t_bad,  1'b1, 1'b0, 1'b0, 32'h118, lu);

    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    step(t_addi, 1'b1, 1'b0, 1'b0, 32'h200, lu);

    pc = 32'h1000;
    lu = 1'b0; st = 1'b0; v = 1'b1;
    t  = t_addi;
    for (int i = 0; i < 400; i++) begin
      if (!(lu || st)) begin
        t  = rand_txn();
        v  = ($urandom_range(0, 7) != 0);
        pc = pc + 32'd4;
      end
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step(t, v, st, fl, pc, lu);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
